seg7_capture: RTL and testbench

Inverse of the team's hex-to-7-segment decoder. Samples a time-multiplexed, active-low 7-segment display bus (segments plus digit enables), filters glitches, maps each stable segment pattern back to its 4-bit hex value, and assembles one multi-digit word per display frame. The word is delivered through a valid/ready handshake. Used as a display read-back monitor in board self-test and as a loopback checker behind the display driver.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_encoder.sv | 35 +++
 rtl/seg7_capture.sv | 175 +++++++++++++++++
 tb/tb_seg7_capture.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment-pattern type (index 0 = segment a),
// active-low code constants for hex digits 0..F, and the capture output states.
package seg7_pkg;

  localparam int SEG_W = 7;

  typedef logic [0:SEG_W-1] seg_t;

  localparam seg_t SEG_0 = 7'b0000001;
  localparam seg_t SEG_1 = 7'b1001111;
  localparam seg_t SEG_2 = 7'b0010010;
  localparam seg_t SEG_3 = 7'b0000110;
  localparam seg_t SEG_4 = 7'b1001100;
  localparam seg_t SEG_5 = 7'b0100100;
  localparam seg_t SEG_6 = 7'b0100000;
  localparam seg_t SEG_7 = 7'b0001111;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0001100;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b1100000;
  localparam seg_t SEG_C = 7'b0110001;
  localparam seg_t SEG_D = 7'b1000010;
  localparam seg_t SEG_E = 7'b0110000;
  localparam seg_t SEG_F = 7'b0111000;

  typedef enum logic {ST_EMPTY, ST_FULL} out_state_e;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational lookup from an active-low segment pattern back to its hex nibble.
// Unknown patterns report o_valid = 0 with nibble 0.
module seg7_encoder
  import seg7_pkg::*;
(
  input  seg_t       i_pat,
  output logic       o_valid,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_valid  = 1'b1;
    o_nibble = 4'h0;
    case (i_pat)
      SEG_0: o_nibble = 4'h0;
      SEG_1: o_nibble = 4'h1;
      SEG_2: o_nibble = 4'h2;
      SEG_3: o_nibble = 4'h3;
      SEG_4: o_nibble = 4'h4;
      SEG_5: o_nibble = 4'h5;
      SEG_6: o_nibble = 4'h6;
      SEG_7: o_nibble = 4'h7;
      SEG_8: o_nibble = 4'h8;
      SEG_9: o_nibble = 4'h9;
      SEG_A: o_nibble = 4'hA;
      SEG_B: o_nibble = 4'hB;
      SEG_C: o_nibble = 4'hC;
      SEG_D: o_nibble = 4'hD;
      SEG_E: o_nibble = 4'hE;
      SEG_F: o_nibble = 4'hF;
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Read-back monitor for a multiplexed active-low 7-segment bus: debounce, decode,
// assemble one word per frame, valid/ready output. SEG7_CAPTURE_DP_EN adds decimal points.
//
// state    | meaning
// ST_EMPTY | no word pending; next complete frame is loaded
// ST_FULL  | word held on value/digit_err until the handshake
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_en,
  input  seg_t                seg_in,
  input  logic [DIGITS-1:0]   dig_en,
`ifdef SEG7_CAPTURE_DP_EN
  input  logic                dp_in,
  output logic [DIGITS-1:0]   dp_out,
`endif
  output logic [4*DIGITS-1:0] value,
  output logic [DIGITS-1:0]   digit_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun
);

`ifdef SEG7_CAPTURE_DP_EN
  localparam int PAIR_W = DIGITS + 1 + SEG_W;
`else
  localparam int PAIR_W = DIGITS + SEG_W;
`endif
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  logic [PAIR_W-1:0]   w_pair;
  logic [PAIR_W-1:0]   r_pair;
  logic                r_pair_vld;
  logic [CNT_W-1:0]    r_remain;
  logic [3:0]          w_zeros;
  logic                w_usable;
  logic                w_same;
  logic                w_cap;
  logic [DIGITS-1:0]   w_sel;
  logic                w_enc_ok;
  logic [3:0]          w_nib;
  logic [4*DIGITS-1:0] r_stage_val, w_stage_val;
  logic [DIGITS-1:0]   r_stage_err, w_stage_err;
  logic [DIGITS-1:0]   r_captured, w_captured;
  logic                w_frame_done;
  logic                w_load;
  logic                w_set_ovr;
  out_state_e          r_state, w_state;

`ifdef SEG7_CAPTURE_DP_EN
  logic [DIGITS-1:0]   r_stage_dp, w_stage_dp;
  assign w_pair = {dig_en, dp_in, seg_in};
`else
  assign w_pair = {dig_en, seg_in};
`endif

  seg7_encoder u_enc (
    .i_pat    (seg_in),
    .o_valid  (w_enc_ok),
    .o_nibble (w_nib)
  );

  always_comb begin
    w_zeros = 4'd0;
    for (int i = 0; i < DIGITS; i++) w_zeros = w_zeros + {3'b000, ~dig_en[i]};
  end

  assign w_sel    = ~dig_en;
  assign w_usable = (w_zeros == 4'd1);
  assign w_same   = r_pair_vld && (w_pair == r_pair);
  // A fresh pair already counts as one sample, so STABLE_CYCLES == 1 captures immediately.
  assign w_cap    = sample_en && w_usable &&
                    (w_same ? (r_remain == CNT_W'(1)) : (STABLE_CYCLES == 1));

  always_comb begin
    w_stage_val = r_stage_val;
    w_stage_err = r_stage_err;
`ifdef SEG7_CAPTURE_DP_EN
    w_stage_dp  = r_stage_dp;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (w_cap && w_sel[i]) begin
        w_stage_val[4*i +: 4] = w_nib;
        w_stage_err[i]        = ~w_enc_ok;
`ifdef SEG7_CAPTURE_DP_EN
        w_stage_dp[i]         = ~dp_in;
`endif
      end
    end
  end

  assign w_captured   = r_captured | (w_cap ? w_sel : '0);
  assign w_frame_done = w_cap && (&w_captured);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pair      <= '0;
      r_pair_vld  <= 1'b0;
      r_remain    <= '0;
      r_stage_val <= '0;
      r_stage_err <= '0;
      r_captured  <= '0;
`ifdef SEG7_CAPTURE_DP_EN
      r_stage_dp  <= '0;
`endif
    end else if (sample_en) begin
      if (!w_usable) begin
        r_pair_vld <= 1'b0;
      end else if (!w_same) begin
        r_pair     <= w_pair;
        r_pair_vld <= 1'b1;
        r_remain   <= CNT_W'(STABLE_CYCLES - 1);
      end else if (r_remain != '0) begin
        r_remain <= r_remain - CNT_W'(1);
      end
      r_stage_val <= w_stage_val;
      r_stage_err <= w_stage_err;
`ifdef SEG7_CAPTURE_DP_EN
      r_stage_dp  <= w_stage_dp;
`endif
      r_captured  <= w_frame_done ? '0 : w_captured;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_load    = 1'b0;
    w_set_ovr = 1'b0;
    case (r_state)
      ST_EMPTY: if (w_frame_done) begin
        w_state = ST_FULL;
        w_load  = 1'b1;
      end
      ST_FULL: begin
        if (out_ready) begin
          if (w_frame_done) w_load  = 1'b1;
          else              w_state = ST_EMPTY;
        end else if (w_frame_done) begin
          w_set_ovr = 1'b1;
        end
      end
      default: w_state = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_EMPTY;
      value     <= '0;
      digit_err <= '0;
      overrun   <= 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
      dp_out    <= '0;
`endif
    end else begin
      r_state <= w_state;
      if (w_set_ovr) overrun <= 1'b1;
      if (w_load) begin
        value     <= w_stage_val;
        digit_err <= w_stage_err;
`ifdef SEG7_CAPTURE_DP_EN
        dp_out    <= w_stage_dp;
`endif
      end
    end
  end

  assign out_valid = (r_state == ST_FULL);

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture (DIGITS=4, STABLE_CYCLES=3): expected words are
// queued at stimulus time and popped by a monitor on each handshake.
module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic [0:6]  seg_in;
  logic [3:0]  dig_en;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
`ifdef SEG7_CAPTURE_DP_EN
  logic        dp_in = 1'b1;
  logic [3:0]  dp_out;
`endif

  int total = 0;
  int bad   = 0;
  logic [19:0] q[$];

  always #5 clk = ~clk;

  seg7_capture #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .seg_in    (seg_in),
    .dig_en    (dig_en),
`ifdef SEG7_CAPTURE_DP_EN
    .dp_in     (dp_in),
    .dp_out    (dp_out),
`endif
    .value     (value),
    .digit_err (digit_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  function automatic logic [0:6] pat(input int h);
    case (h)
      0:  pat = 7'b0000001;  1:  pat = 7'b1001111;
      2:  pat = 7'b0010010;  3:  pat = 7'b0000110;
      4:  pat = 7'b1001100;  5:  pat = 7'b0100100;
      6:  pat = 7'b0100000;  7:  pat = 7'b0001111;
      8:  pat = 7'b0000000;  9:  pat = 7'b0001100;
      10: pat = 7'b0001000;  11: pat = 7'b1100000;
      12: pat = 7'b0110001;  13: pat = 7'b1000010;
      14: pat = 7'b0110000;  15: pat = 7'b0111000;
      default: pat = 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Handshake monitor: a word seen valid&ready at negedge transfers on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got value=%h err=%b, expected none", value, digit_err);
      end else begin
        logic [19:0] e;
        e = q.pop_front();
        chk("word_value", {16'h0, value}, {16'h0, e[19:4]});
        chk("word_err", {28'h0, digit_err}, {28'h0, e[3:0]});
      end
    end
  end

  task automatic send_digit(input int idx, input int h, input int n);
    dig_en    = ~(4'(1 << idx));
    seg_in    = pat(h);
    sample_en = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int d0, input int d1, input int d2, input int d3);
    send_digit(0, d0, 3);
    send_digit(1, d1, 3);
    send_digit(2, d2, 3);
    send_digit(3, d3, 3);
  endtask

  task automatic idle(input int n);
    dig_en = 4'hF;
    seg_in = 7'b1111111;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_value"}, {16'h0, value}, 32'h0);
    chk({tag, "_err"}, {28'h0, digit_err}, 32'h0);
    chk({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
    chk({tag, "_overrun"}, {31'h0, overrun}, 32'h0);
  endtask

  initial begin
    rst       = 1'b1;
    sample_en = 1'b0;
    seg_in    = 7'b1111111;
    dig_en    = 4'hF;
    out_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Clean frame
    out_ready = 1'b1;
    q.push_back({16'h4321, 4'b0000});
    send_frame(1, 2, 3, 4);
    idle(3);

    // Glitch filter: two 8s never reach the threshold
    q.push_back({16'h7650, 4'b0000});
    send_digit(0, 8, 2);
    send_digit(0, 0, 1);
    send_digit(0, 0, 3);
    send_digit(1, 5, 3);
    send_digit(2, 6, 3);
    send_digit(3, 7, 3);
    idle(3);

    // Invalid pattern on digit 2
    q.push_back({16'hB0A9, 4'b0100});
    send_frame(9, 10, 16, 11);
    idle(3);

    // Overrun: second frame dropped while the first is unconsumed
    out_ready = 1'b0;
    q.push_back({16'h89CD, 4'b0000});
    send_frame(13, 12, 9, 8);
    idle(2);
    @(negedge clk);
    chk("ovr_first_valid", {31'h0, out_valid}, 32'h1);
    chk("ovr_first_flag", {31'h0, overrun}, 32'h0);
    @(posedge clk); #1;
    send_frame(0, 14, 15, 0);
    idle(2);
    @(negedge clk);
    chk("ovr_hold_value", {16'h0, value}, 32'h89CD);
    chk("ovr_flag", {31'h0, overrun}, 32'h1);
    chk("ovr_hold_valid", {31'h0, out_valid}, 32'h1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(3);
    @(negedge clk);
    chk("ovr_drained_valid", {31'h0, out_valid}, 32'h0);
    chk("ovr_sticky", {31'h0, overrun}, 32'h1);

    // Reset clears the sticky overrun and the held word
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_clear");
    @(posedge clk); #1;
    rst = 1'b0;

    // Handshake coincident with a new frame completing while FULL
    out_ready = 1'b0;
    q.push_back({16'h0F0E, 4'b0000});
    q.push_back({16'h4567, 4'b0000});
    send_frame(14, 0, 15, 0);
    idle(2);
    send_digit(0, 7, 3);
    send_digit(1, 6, 3);
    send_digit(2, 5, 3);
    send_digit(3, 4, 2);
    out_ready = 1'b1;
    send_digit(3, 4, 1);
    @(negedge clk);
    chk("coinc_valid", {31'h0, out_valid}, 32'h1);
    chk("coinc_overrun", {31'h0, overrun}, 32'h0);
    @(posedge clk); #1;
    idle(3);

    // Reset mid-frame: digits captured before reset are discarded
    out_ready = 1'b1;
    send_digit(0, 1, 3);
    send_digit(1, 2, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    send_digit(2, 3, 3);
    send_digit(3, 4, 3);
    @(negedge clk);
    chk("midrst_no_valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk); #1;
    idle(4);

    begin
      int guard = 0;
      while (q.size() != 0 && guard < 50) begin
        @(posedge clk);
        guard++;
      end
    end
    chk("queue_drained", q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
